// File: rtl/imem_arbiter.sv
// Two-requester arbiter for the instruction memory port: fetch priority, loader anti-starvation, lock mode.
// Optional write protect: define IMEM_ARB_WP_EN so loader writes only take effect while LOCKED.
module imem_arbiter #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32,
  parameter int MAX_WAIT    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   if_req_i,
  input  logic [INS_ADDRESS-1:0] if_addr_i,
  output logic                   if_gnt_o,
  output logic                   if_rvalid_o,
  output logic [INS_W-1:0]       if_rdata_o,
  input  logic                   ld_req_i,
  input  logic                   ld_we_i,
  input  logic [INS_ADDRESS-1:0] ld_addr_i,
  input  logic [INS_W-1:0]       ld_wdata_i,
  input  logic                   ld_lock_i,
  output logic                   ld_gnt_o,
  output logic                   ld_rvalid_o,
  output logic [INS_W-1:0]       ld_rdata_o,
  output logic                   ld_err_o,
  output logic                   locked_o,
  output logic                   mem_en_o,
  output logic                   mem_we_o,
  output logic [INS_ADDRESS-3:0] mem_addr_o,
  output logic [INS_W-1:0]       mem_wdata_o,
  input  logic [INS_W-1:0]       mem_rdata_i
);

  typedef enum logic [1:0] {RUN, DRAIN, LOCKED} state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       if_pend;
  logic       ld_pend;
  logic       ld_err;
  logic       force_ld;
  logic       wp_block;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{if_addr_i[1:0], ld_addr_i[1:0]};

  assign force_ld = (state == RUN) && ld_req_i && (wait_cnt == 4'(MAX_WAIT));

`ifdef IMEM_ARB_WP_EN
  assign wp_block = ld_we_i && (state != LOCKED);
`else
  assign wp_block = 1'b0;
`endif

  // Grants are held low during reset so every strobe reads 0 while rst_ni is asserted.
  always_comb begin
    if_gnt_o = 1'b0;
    ld_gnt_o = 1'b0;
    if (rst_ni) begin
      case (state)
        RUN: begin
          if_gnt_o = if_req_i && !force_ld;
          ld_gnt_o = ld_req_i && (!if_req_i || force_ld);
        end
        default: ld_gnt_o = ld_req_i;
      endcase
    end
  end

  assign mem_en_o    = if_gnt_o | (ld_gnt_o & ~wp_block);
  assign mem_we_o    = ld_gnt_o & ld_we_i & ~wp_block;
  assign mem_addr_o  = ld_gnt_o ? ld_addr_i[INS_ADDRESS-1:2] : if_addr_i[INS_ADDRESS-1:2];
  assign mem_wdata_o = ld_wdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= RUN;
      wait_cnt <= '0;
      if_pend  <= 1'b0;
      ld_pend  <= 1'b0;
      ld_err   <= 1'b0;
    end else begin
      if_pend <= if_gnt_o;
      ld_pend <= ld_gnt_o & ~ld_we_i;
      ld_err  <= ld_gnt_o & ld_we_i & wp_block;

      if (ld_gnt_o)
        wait_cnt <= '0;
      else if (ld_req_i && wait_cnt != 4'(MAX_WAIT))
        wait_cnt <= wait_cnt + 4'd1;

      case (state)
        RUN:    if (ld_lock_i) state <= DRAIN;
        // No fetch is granted in DRAIN, so any fetch still in flight is answered
        // during the DRAIN cycle itself and LOCKED can follow immediately.
        DRAIN:  state <= ld_lock_i ? LOCKED : RUN;
        LOCKED: begin
          if (!ld_lock_i) begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign if_rvalid_o = if_pend;
  assign ld_rvalid_o = ld_pend;
  assign if_rdata_o  = if_pend ? mem_rdata_i : '0;
  assign ld_rdata_o  = ld_pend ? mem_rdata_i : '0;
  assign ld_err_o    = ld_err;
  assign locked_o    = (state == LOCKED);

endmodule
